// File: rtl/rat_pkg.sv
// Shared types for the rat path player: direction coding, FSM states, maze width.
package rat_pkg;

   localparam int MAZE_W = 4;

   // X moves when both direction bits are equal, Y moves otherwise.
   typedef enum logic [1:0] {
      DIR_XP = 2'b00,
      DIR_YP = 2'b01,
      DIR_YM = 2'b10,
      DIR_XM = 2'b11
   } dir_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_PRESENT,
      S_HOLD,
      S_DONE,
      S_ERR
   } state_e;

endpackage

// File: rtl/rat_step_calc.sv
// Next-cell calculator: applies one direction step to (x, y) and flags leaving the maze.
// Purely combinational; out-of-range steps keep the old coordinates and raise oob.
module rat_step_calc
   import rat_pkg::*;
(
   input  logic [MAZE_W-1:0] x,
   input  logic [MAZE_W-1:0] y,
   input  logic [1:0]        dir,
   output logic [MAZE_W-1:0] nx,
   output logic [MAZE_W-1:0] ny,
   output logic              oob
);

   always_comb begin
      nx  = x;
      ny  = y;
      oob = 1'b0;
      case (dir_e'(dir))
         DIR_XP: if (x == '1) oob = 1'b1; else nx = x + 1'b1;
         DIR_XM: if (x == '0) oob = 1'b1; else nx = x - 1'b1;
         DIR_YP: if (y == '1) oob = 1'b1; else ny = y + 1'b1;
         DIR_YM: if (y == '0) oob = 1'b1; else ny = y - 1'b1;
         default: oob = 1'b0;
      endcase
   end

endmodule

// File: rtl/rat_path_player.sv
// Replays a queued rat path as valid/ready moves, pacing accepted moves by HOLD idle cycles.
// All outputs registered: pop and offer appear the cycle after CHECK; mv_valid holds until mv_ready.
module rat_path_player
   import rat_pkg::*;
#(
   parameter int HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              emptyq,
   input  logic [1:0]        qdata,
   output logic              dequeue,
   output logic              mv_valid,
   input  logic              mv_ready,
   output logic [1:0]        mv_dir,
   output logic [MAZE_W-1:0] mv_x,
   output logic [MAZE_W-1:0] mv_y,
   output logic [MAZE_W-1:0] x,
   output logic [MAZE_W-1:0] y,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

   state_e            state;
   logic              run_q;
   logic [CW-1:0]     cnt;
   logic [MAZE_W-1:0] nx;
   logic [MAZE_W-1:0] ny;
   logic              oob;

   // Target is computed straight from the queue head so it is latched in the CHECK cycle.
   rat_step_calc u_step (
      .x   (x),
      .y   (y),
      .dir (qdata),
      .nx  (nx),
      .ny  (ny),
      .oob (oob)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         run_q    <= 1'b0;
         cnt      <= '0;
         x        <= '0;
         y        <= '0;
         mv_dir   <= 2'b00;
         mv_x     <= '0;
         mv_y     <= '0;
         mv_valid <= 1'b0;
         dequeue  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         run_q   <= run;
         dequeue <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run && !run_q) begin
                  x     <= '0;
                  y     <= '0;
                  busy  <= 1'b1;
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (emptyq) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else begin
                  mv_dir <= qdata;
                  if (oob) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_ERR;
                  end else begin
                     mv_x     <= nx;
                     mv_y     <= ny;
                     mv_valid <= 1'b1;
                     dequeue  <= 1'b1;
                     state    <= S_PRESENT;
                  end
               end
            end
            S_PRESENT: begin
               if (mv_ready) begin
                  x        <= mv_x;
                  y        <= mv_y;
                  mv_valid <= 1'b0;
                  cnt      <= CW'(HOLD - 1);
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (cnt == '0) state <= S_CHECK;
               else           cnt   <= cnt - 1'b1;
            end
            S_DONE: state <= S_IDLE;
            S_ERR: begin
               if (!run) begin
                  err   <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rat_path_player.sv
// Directed bench for rat_path_player: queue model, hand-computed expectations, immediate assertions.
module tb_rat_path_player;

   bit         clk = 1'b0;
   logic       rst;
   logic       run;
   logic       emptyq;
   logic [1:0] qdata;
   logic       dequeue;
   logic       mv_valid;
   logic       mv_ready;
   logic [1:0] mv_dir;
   logic [3:0] mv_x, mv_y, x, y;
   logic       busy, done, err;

   int         n_cmp = 0;
   int         n_err = 0;

   // Queue model: pops on any clock edge that sees dequeue.
   logic [1:0] qmem [0:7];
   int         qbase = 0;
   int         qlen  = 0;
   int         deq_cnt = 0;
   bit         bad_deq = 1'b0;

   assign emptyq = ((deq_cnt - qbase) >= qlen);
   assign qdata  = qmem[3'(deq_cnt - qbase)];

   always @(posedge clk) begin
      if (dequeue) deq_cnt <= deq_cnt + 1;
      if (dequeue && emptyq) bad_deq <= 1'b1;
   end

   always #5 clk = ~clk;

   rat_path_player #(.HOLD(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .emptyq   (emptyq),
      .qdata    (qdata),
      .dequeue  (dequeue),
      .mv_valid (mv_valid),
      .mv_ready (mv_ready),
      .mv_dir   (mv_dir),
      .mv_x     (mv_x),
      .mv_y     (mv_y),
      .x        (x),
      .y        (y),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic qload(input int n, input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2);
      qbase   = deq_cnt;
      qmem[0] = d0;
      qmem[1] = d1;
      qmem[2] = d2;
      for (int i = 3; i < 8; i++) qmem[i] = 2'b00;
      qlen    = n;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; mv_ready = 1'b0;
      qload(0, 2'b00, 2'b00, 2'b00);
      step(); step();
      chk("rst_busy",  32'(busy), 0);
      chk("rst_valid", 32'(mv_valid), 0);
      chk("rst_deq",   32'(dequeue), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_err",   32'(err), 0);
      chk("rst_xy",    32'({x, y, mv_x, mv_y, mv_dir}), 0);
      rst = 1'b0;
      step();

      // Three-move path {X+, X+, Y+} with the sink always ready
      qload(3, 2'b00, 2'b00, 2'b01);
      mv_ready = 1'b1; run = 1'b1;
      step();
      chk("p1_busy", 32'(busy), 1);
      chk("p1_valid0", 32'(mv_valid), 0);
      step();
      chk("p1_m1_valid", 32'(mv_valid), 1);
      chk("p1_m1_deq", 32'(dequeue), 1);
      chk("p1_m1_tgt", 32'({mv_x, mv_y}), 32'h10);
      step();
      chk("p1_m1_xy", 32'({x, y}), 32'h10);
      chk("p1_m1_drop", 32'({mv_valid, dequeue}), 0);
      repeat (4) step();
      chk("p1_hold_gap", 32'({mv_valid, busy}), 32'h1);
      step();
      chk("p1_m2_valid", 32'(mv_valid), 1);
      chk("p1_m2_tgt", 32'({mv_x, mv_y}), 32'h20);
      step();
      chk("p1_m2_xy", 32'({x, y}), 32'h20);
      repeat (5) step();
      chk("p1_m3_valid", 32'(mv_valid), 1);
      chk("p1_m3_tgt", 32'({mv_dir, mv_x, mv_y}), 32'h121);
      step();
      chk("p1_m3_xy", 32'({x, y}), 32'h21);
      repeat (4) step();
      chk("p1_pre_done", 32'({busy, done}), 32'h2);
      step();
      chk("p1_done", 32'({done, busy}), 32'h2);
      chk("p1_final_xy", 32'({x, y}), 32'h21);
      chk("p1_deq_count", 32'(deq_cnt - qbase), 3);
      step();
      chk("p1_done_pulse", 32'(done), 0);

      // run still high after completion: no restart
      repeat (3) step();
      chk("norestart", 32'({busy, done, mv_valid}), 0);

      // Toggle run to restart; sink stalls ten cycles on a Y+ move
      run = 1'b0; mv_ready = 1'b0;
      qload(1, 2'b01, 2'b00, 2'b00);
      step();
      run = 1'b1;
      step();
      chk("r_busy", 32'(busy), 1);
      chk("r_origin", 32'({x, y}), 0);
      step();
      chk("stall_valid0", 32'({mv_valid, mv_x, mv_y}), 32'h101);
      chk("stall_deq0", 32'(dequeue), 1);
      for (int i = 1; i < 10; i++) begin
         step();
         chk("stall_valid", 32'({mv_valid, mv_dir, mv_x, mv_y}), 32'h501);
         chk("stall_deq", 32'(dequeue), 0);
      end
      mv_ready = 1'b1;
      step();
      chk("stall_xfer", 32'({mv_valid, x, y}), 32'h001);
      mv_ready = 1'b0; run = 1'b0;
      repeat (4) step();
      step();
      chk("stall_done", 32'({done, x, y}), 32'h101);
      chk("stall_deq_count", 32'(deq_cnt - qbase), 1);
      step();

      // Y- from the origin leaves the maze
      qload(1, 2'b10, 2'b00, 2'b00);
      run = 1'b1;
      step();
      step();
      chk("ym_err", 32'({err, busy, mv_valid, dequeue}), 32'h8);
      repeat (3) step();
      chk("ym_err_held", 32'(err), 1);
      run = 1'b0;
      step();
      chk("ym_err_clear", 32'({err, busy}), 0);
      chk("ym_no_deq", 32'(deq_cnt - qbase), 0);

      // X- from the origin also leaves the maze
      qload(1, 2'b11, 2'b00, 2'b00);
      run = 1'b1;
      step();
      step();
      chk("xm_err", 32'({err, dequeue}), 32'h2);
      run = 1'b0;
      step();
      chk("xm_err_clear", 32'(err), 0);

      // Empty queue at start
      qload(0, 2'b00, 2'b00, 2'b00);
      step();
      run = 1'b1;
      step();
      chk("empty_check", 32'({done, busy}), 32'h1);
      step();
      chk("empty_done", 32'({done, x, y}), 32'h100);
      step();
      chk("empty_pulse", 32'(done), 0);
      chk("empty_no_deq", 32'(deq_cnt - qbase), 0);
      run = 1'b0;
      step();

      // Reset during HOLD after the first move
      qload(2, 2'b00, 2'b01, 2'b00);
      mv_ready = 1'b1;
      run = 1'b1;
      step();
      step();
      step();
      chk("mid_xfer", 32'({x, y}), 32'h10);
      step();
      rst = 1'b1; run = 1'b0;
      step();
      chk("mid_rst", 32'({busy, mv_valid, dequeue, x, y}), 0);
      chk("mid_rst_mv", 32'({mv_dir, mv_x, mv_y}), 0);
      rst = 1'b0;
      repeat (6) step();
      chk("post_rst_idle", 32'({busy, mv_valid}), 0);
      chk("post_rst_deq", 32'(deq_cnt - qbase), 1);

      chk("deq_while_empty", 32'(bad_deq), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
